// File: rtl/wci_initiator_pkg.sv
// wci_initiator_pkg: shared WCI command/response encodings, field offsets and initiator states.
package wci_initiator_pkg;

    typedef enum logic [2:0] {
        MCMD_IDLE = 3'b000,
        MCMD_WR   = 3'b001,
        MCMD_RD   = 3'b010
    } mcmd_e;

    typedef enum logic [1:0] {
        SRESP_NULL = 2'b00,
        SRESP_DVA  = 2'b01,
        SRESP_FAIL = 2'b10,
        SRESP_ERR  = 2'b11
    } sresp_e;

    typedef enum logic [1:0] {
        CODE_DVA     = 2'b00,
        CODE_FAIL    = 2'b01,
        CODE_ERR     = 2'b10,
        CODE_TIMEOUT = 2'b11
    } code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam int REQ_W      = 60;
    localparam int RESP_W     = 34;
    localparam int MCMD_LSB   = 57;
    localparam int SPACE_BIT  = 56;
    localparam int BYTEEN_LSB = 52;
    localparam int ADDR_LSB   = 32;
    localparam int SRESP_LSB  = 32;

    // Non-NULL SResp values map onto host codes one step below their wire encoding.
    function automatic code_e sresp_to_code(input sresp_e r);
        return code_e'(r - 2'd1);
    endfunction

endpackage

// File: rtl/wci_initiator.sv
// wci_initiator: single-outstanding WCI master bridging a host request/completion port to a worker.
module wci_initiator
    import wci_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_req_valid,
    output logic              host_req_ready,
    input  logic              host_req_write,
    input  logic              host_req_space,
    input  logic [3:0]        host_req_byteen,
    input  logic [19:0]       host_req_addr,
    input  logic [31:0]       host_req_data,
    output logic              host_resp_valid,
    input  logic              host_resp_ready,
    output logic [1:0]        host_resp_code,
    output logic [31:0]       host_resp_data,
    output logic              timeout_sticky,
    input  logic              host_clear,
    output logic [REQ_W-1:0]  wci_m_req,
    input  logic [RESP_W-1:0] wci_m_resp,
    input  logic              wci_m_SThreadBusy,
    input  logic [1:0]        wci_m_SFlag,
    output logic [1:0]        sflag_q,
    output logic [1:0]        wci_m_MFlag
);

    state_e      state, state_nx;
    logic        req_write, req_space;
    logic [3:0]  req_byteen;
    logic [19:0] req_addr;
    logic [31:0] req_data;
    logic [15:0] cnt;
    logic        accept, capture, expire;
    sresp_e      sresp;

    assign sresp       = sresp_e'(wci_m_resp[SRESP_LSB +: 2]);
    assign wci_m_MFlag = 2'b00;

    always_comb begin
        state_nx        = state;
        accept          = 1'b0;
        capture         = 1'b0;
        expire          = 1'b0;
        host_req_ready  = state == ST_IDLE;
        host_resp_valid = state == ST_RESP;
        wci_m_req       = '0;
        case (state)
            ST_IDLE: begin
                accept   = host_req_valid;
                state_nx = host_req_valid ? ST_ARB : ST_IDLE;
            end
            ST_ARB:   state_nx = wci_m_SThreadBusy ? ST_ARB : ST_ISSUE;
            ST_ISSUE: begin
                wci_m_req = {req_write ? MCMD_WR : MCMD_RD, req_space, req_byteen, req_addr, req_data};
                state_nx  = ST_WAIT;
            end
            ST_WAIT: begin
                capture  = sresp != SRESP_NULL;
                expire   = !capture && cnt == 16'(TIMEOUT - 1);
                state_nx = (capture || expire) ? ST_RESP : ST_WAIT;
            end
            ST_RESP:  state_nx = host_resp_ready ? ST_IDLE : ST_RESP;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            req_write      <= 1'b0;
            req_space      <= 1'b0;
            req_byteen     <= '0;
            req_addr       <= '0;
            req_data       <= '0;
            cnt            <= '0;
            host_resp_code <= CODE_DVA;
            host_resp_data <= '0;
            timeout_sticky <= 1'b0;
            sflag_q        <= '0;
        end else begin
            state   <= state_nx;
            sflag_q <= wci_m_SFlag;
            cnt     <= (state == ST_WAIT) ? cnt + 16'd1 : '0;
            if (accept) begin
                req_write  <= host_req_write;
                req_space  <= host_req_space;
                req_byteen <= host_req_byteen;
                req_addr   <= host_req_addr;
                req_data   <= host_req_data;
            end
            if (capture) begin
                host_resp_code <= sresp_to_code(sresp);
                host_resp_data <= wci_m_resp[31:0];
            end else if (expire) begin
                host_resp_code <= CODE_TIMEOUT;
                host_resp_data <= '0;
            end
            // A timeout in the same cycle as host_clear keeps the flag set.
            timeout_sticky <= expire | (timeout_sticky & ~host_clear);
        end
    end

endmodule

// File: tb/tb_wci_initiator.sv
// tb_wci_initiator: directed checks of the WCI initiator with a short (8-cycle) timeout.
module tb_wci_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_req_valid = 1'b0;
    logic        host_req_ready;
    logic        host_req_write = 1'b0;
    logic        host_req_space = 1'b0;
    logic [3:0]  host_req_byteen = '0;
    logic [19:0] host_req_addr = '0;
    logic [31:0] host_req_data = '0;
    logic        host_resp_valid;
    logic        host_resp_ready = 1'b0;
    logic [1:0]  host_resp_code;
    logic [31:0] host_resp_data;
    logic        timeout_sticky;
    logic        host_clear = 1'b0;
    logic [59:0] wci_m_req;
    logic [33:0] wci_m_resp = '0;
    logic        wci_m_SThreadBusy = 1'b0;
    logic [1:0]  wci_m_SFlag = '0;
    logic [1:0]  sflag_q;
    logic [1:0]  wci_m_MFlag;

    int checks = 0;
    int errors = 0;

    wci_initiator #(.TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_write(host_req_write), .host_req_space(host_req_space),
        .host_req_byteen(host_req_byteen), .host_req_addr(host_req_addr),
        .host_req_data(host_req_data), .host_resp_valid(host_resp_valid),
        .host_resp_ready(host_resp_ready), .host_resp_code(host_resp_code),
        .host_resp_data(host_resp_data), .timeout_sticky(timeout_sticky),
        .host_clear(host_clear), .wci_m_req(wci_m_req), .wci_m_resp(wci_m_resp),
        .wci_m_SThreadBusy(wci_m_SThreadBusy), .wci_m_SFlag(wci_m_SFlag),
        .sflag_q(sflag_q), .wci_m_MFlag(wci_m_MFlag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag, input logic [1:0] code, input logic [31:0] data);
        check({tag, "_req"}, wci_m_req, 0);
        check({tag, "_rvalid"}, host_resp_valid, 0);
        check({tag, "_qready"}, host_req_ready, 1);
        check({tag, "_code"}, host_resp_code, code);
        check({tag, "_data"}, host_resp_data, data);
    endtask

    task automatic send(input logic w, input logic s, input logic [3:0] be, input logic [19:0] a, input logic [31:0] d);
        host_req_write  = w;
        host_req_space  = s;
        host_req_byteen = be;
        host_req_addr   = a;
        host_req_data   = d;
        host_req_valid  = 1'b1;
        tick();
        host_req_valid  = 1'b0;
        host_req_data   = '0;
    endtask

    task automatic wait_issue(input string tag, input int exp_n);
        int n = 0;
        while (wci_m_req[59:57] == 3'b000 && n < 50) begin
            tick();
            n++;
        end
        check(tag, n, exp_n);
    endtask

    task automatic respond(input logic [1:0] sr, input logic [31:0] sd, input int delay);
        for (int i = 0; i < delay; i++) tick();
        wci_m_resp = {sr, sd};
        tick();
        wci_m_resp = '0;
    endtask

    task automatic consume(input string tag);
        host_resp_ready = 1'b1;
        tick();
        host_resp_ready = 1'b0;
        check(tag, host_resp_valid, 0);
    endtask

    initial begin
        tick();
        tick();
        check_idle_outputs("rst", 2'b00, 32'h0);
        check("rst_sticky", timeout_sticky, 0);
        check("rst_sflag", sflag_q, 0);
        check("mflag", wci_m_MFlag, 0);
        rst_n = 1'b1;
        tick();

        // Config write, DVA three cycles after MCmd
        send(1'b1, 1'b1, 4'hF, 20'h00004, 32'hDEADBEEF);
        check("wr_arb_req", wci_m_req, 0);
        check("wr_arb_qready", host_req_ready, 0);
        wait_issue("wr_issue_lat", 1);
        check("wr_req", wci_m_req, {3'b001, 1'b1, 4'hF, 20'h00004, 32'hDEADBEEF});
        tick();
        check("wr_req_one_cycle", wci_m_req, 0);
        respond(2'b01, 32'h0, 2);
        check("wr_rvalid", host_resp_valid, 1);
        check("wr_code", host_resp_code, 2'b00);
        consume("wr_done");

        // Config read
        send(1'b0, 1'b1, 4'hF, 20'h00010, 32'h0);
        wait_issue("rd_issue_lat", 1);
        check("rd_req", wci_m_req, {3'b010, 1'b1, 4'hF, 20'h00010, 32'h0});
        respond(2'b01, 32'h12345678, 1);
        check("rd_rvalid", host_resp_valid, 1);
        check("rd_code", host_resp_code, 2'b00);
        check("rd_data", host_resp_data, 32'h12345678);
        consume("rd_done");

        // SThreadBusy stalls arbitration for 10 cycles
        wci_m_SThreadBusy = 1'b1;
        send(1'b1, 1'b0, 4'h3, 20'h00100, 32'h0000_00A5);
        for (int i = 0; i < 10; i++) begin
            check("busy_mcmd_idle", wci_m_req[59:57], 3'b000);
            tick();
        end
        wci_m_SThreadBusy = 1'b0;
        wait_issue("busy_issue_lat", 1);
        check("busy_req", wci_m_req, {3'b001, 1'b0, 4'h3, 20'h00100, 32'h0000_00A5});
        respond(2'b01, 32'h0, 1);
        consume("busy_done");

        // Silent worker: timeout, with host_clear colliding on the timeout cycle
        send(1'b0, 1'b1, 4'hF, 20'h00040, 32'h0);
        wait_issue("to_issue_lat", 1);
        for (int i = 0; i < 8; i++) tick();
        check("to_not_yet", host_resp_valid, 0);
        host_clear = 1'b1;
        tick();
        host_clear = 1'b0;
        check("to_rvalid", host_resp_valid, 1);
        check("to_code", host_resp_code, 2'b11);
        check("to_data", host_resp_data, 32'h0);
        check("to_sticky_set_wins", timeout_sticky, 1);
        wci_m_resp = {2'b01, 32'hAAAA5555};
        tick();
        wci_m_resp = '0;
        check("late_code", host_resp_code, 2'b11);
        check("late_data", host_resp_data, 32'h0);
        consume("to_done");
        wci_m_resp = {2'b01, 32'h11112222};
        tick();
        wci_m_resp = '0;
        check("idle_resp_ignored", host_resp_valid, 0);
        check("idle_resp_data", host_resp_data, 32'h0);
        check("sticky_held", timeout_sticky, 1);
        host_clear = 1'b1;
        tick();
        host_clear = 1'b0;
        check("sticky_cleared", timeout_sticky, 0);

        // ERR on control read, host stalls the completion
        send(1'b0, 1'b0, 4'hF, 20'h00020, 32'h0);
        wait_issue("err_issue_lat", 1);
        check("err_req", wci_m_req, {3'b010, 1'b0, 4'hF, 20'h00020, 32'h0});
        respond(2'b11, 32'hCAFE0001, 1);
        for (int i = 0; i < 5; i++) begin
            check("err_rvalid", host_resp_valid, 1);
            check("err_code", host_resp_code, 2'b10);
            check("err_data", host_resp_data, 32'hCAFE0001);
            check("err_qready", host_req_ready, 0);
            tick();
        end
        consume("err_done");

        // SFlag is a one-cycle delayed copy
        wci_m_SFlag = 2'b10;
        check("sflag_before", sflag_q, 2'b00);
        tick();
        check("sflag_10", sflag_q, 2'b10);
        wci_m_SFlag = 2'b01;
        tick();
        check("sflag_01", sflag_q, 2'b01);

        // Reset during WAIT abandons the request
        send(1'b1, 1'b0, 4'h1, 20'h00008, 32'h00000055);
        wait_issue("rst_issue_lat", 1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_idle_outputs("arst", 2'b00, 32'h0);
        check("arst_sflag", sflag_q, 0);
        check("arst_sticky", timeout_sticky, 0);
        tick();
        rst_n = 1'b1;
        wci_m_SFlag = 2'b00;
        tick();
        check("post_rst_rvalid", host_resp_valid, 0);
        send(1'b0, 1'b0, 4'hC, 20'h00030, 32'h0);
        wait_issue("post_rst_issue_lat", 1);
        check("post_rst_req", wci_m_req, {3'b010, 1'b0, 4'hC, 20'h00030, 32'h0});
        respond(2'b10, 32'h0BADF00D, 1);
        check("post_rst_rvalid2", host_resp_valid, 1);
        check("post_rst_code", host_resp_code, 2'b01);
        check("post_rst_data", host_resp_data, 32'h0BADF00D);
        consume("post_rst_done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
